// File: rtl/counter_pkg.sv
// Shared constants for the 4-bit counter: datapath width and mode encodings.
package counter_pkg;

  localparam int unsigned WIDTH     = 4;
  localparam int unsigned EXT_WIDTH = WIDTH + 1;

  typedef enum logic [1:0] {
    MODE_UP1  = 2'b00,
    MODE_DN1  = 2'b01,
    MODE_DN3  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/counter_if.sv
// Control/status bundle between the counter and whatever drives it.
interface counter_if;
  import counter_pkg::*;

  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             rco;
  logic             load;

  modport master (output enable, output mode, output D,
                  input  Q, input rco, input load);
  modport slave  (input  enable, input mode, input D,
                  output Q, output rco, output load);
endinterface

// File: rtl/counter_4bit.sv
// 4-bit up/down/down-by-3/load counter with registered wrap (rco) and load pulses.
module counter_4bit
  import counter_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  counter_if.slave bus
);

  logic [WIDTH-1:0]     q;
  logic                 rco;
  logic                 load;
  logic [WIDTH-1:0]     q_next;
  logic                 rco_next;
  logic                 load_next;
  logic [EXT_WIDTH-1:0] ext;

  // Next value and flags; the extra top bit of ext is the carry/borrow.
  always_comb begin
    q_next    = q;
    rco_next  = 1'b0;
    load_next = 1'b0;
    ext       = '0;
    if (bus.enable) begin
      case (bus.mode)
        MODE_UP1: begin
          ext      = {1'b0, q} + EXT_WIDTH'(1);
          q_next   = ext[WIDTH-1:0];
          rco_next = ext[WIDTH];
        end
        MODE_DN1: begin
          ext      = {1'b0, q} - EXT_WIDTH'(1);
          q_next   = ext[WIDTH-1:0];
          rco_next = ext[WIDTH];
        end
        MODE_DN3: begin
          ext      = {1'b0, q} - EXT_WIDTH'(3);
          q_next   = ext[WIDTH-1:0];
          rco_next = ext[WIDTH];
        end
        MODE_LOAD: begin
          q_next    = bus.D;
          load_next = 1'b1;
        end
        // Unknown mode holds the count so RTL and netlist agree.
        default: begin
          q_next    = q;
          rco_next  = 1'b0;
          load_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      rco  <= 1'b0;
      load <= 1'b0;
    end else begin
      q    <= q_next;
      rco  <= rco_next;
      load <= load_next;
    end
  end

  assign bus.Q    = q;
  assign bus.rco  = rco;
  assign bus.load = load;

endmodule

// File: tb/tb_counter_4bit.sv
// Scoreboard bench for counter_4bit: directed sequences followed by random cycles.
module tb_counter_4bit;
  import counter_pkg::*;

  typedef struct packed {
    logic [3:0] q;
    logic       rco;
    logic       load;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   mq     = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  counter_if bus ();

  counter_4bit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Drive one cycle, predict its result into the scoreboard, then check after the edge.
  task automatic step(input logic rst, input logic en, input logic [1:0] m,
                      input logic [3:0] d, input string tag);
    exp_t e;
    int   nq;
    @(negedge clk);
    reset      = rst;
    bus.enable = en;
    bus.mode   = m;
    bus.D      = d;
    e.rco  = 1'b0;
    e.load = 1'b0;
    nq     = mq;
    if (rst) begin
      nq = 0;
    end else if (en) begin
      case (m)
        2'b00: begin e.rco = (mq == 15); nq = (mq + 1) % 16;  end
        2'b01: begin e.rco = (mq == 0);  nq = (mq + 15) % 16; end
        2'b10: begin e.rco = (mq < 3);   nq = (mq + 13) % 16; end
        default: begin e.load = 1'b1;    nq = int'(d);        end
      endcase
    end
    mq   = nq;
    e.q  = 4'(nq);
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (bus.Q === e.q) else begin
      errors++;
      $error("FAIL %s Q observed=%0d expected=%0d", tag, bus.Q, e.q);
    end
    checks++;
    assert (bus.rco === e.rco) else begin
      errors++;
      $error("FAIL %s rco observed=%b expected=%b", tag, bus.rco, e.rco);
    end
    checks++;
    assert (bus.load === e.load) else begin
      errors++;
      $error("FAIL %s load observed=%b expected=%b", tag, bus.load, e.load);
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.mode   = 2'b00;
    bus.D      = 4'h0;

    // Reset held two cycles with counting requested.
    step(1'b1, 1'b1, 2'b00, 4'h0, "reset0");
    step(1'b1, 1'b1, 2'b00, 4'h0, "reset1");

    // Up count through the wrap: 1..15, 0 (rco), 1.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 2'b00, 4'h0, "up1");

    // Down by one from 1: 0, 15 (rco), 14.
    step(1'b0, 1'b1, 2'b11, 4'h1, "load1");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b01, 4'h0, "dn1");

    // Down by three from 7: 4, 1, 14 (rco), 11.
    step(1'b0, 1'b1, 2'b11, 4'h7, "load7");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b10, 4'h0, "dn3");

    // Borrow boundaries of down-by-three.
    step(1'b0, 1'b1, 2'b11, 4'h3, "load3");
    step(1'b0, 1'b1, 2'b10, 4'h0, "dn3_from3");
    step(1'b0, 1'b1, 2'b11, 4'h2, "load2");
    step(1'b0, 1'b1, 2'b10, 4'h0, "dn3_from2");

    // Back-to-back rco: 0 -> 15 down, then 15 -> 0 up.
    step(1'b0, 1'b1, 2'b11, 4'h0, "load0");
    step(1'b0, 1'b1, 2'b01, 4'h0, "b2b_dn");
    step(1'b0, 1'b1, 2'b00, 4'h0, "b2b_up");

    // Load A then hold with enable low; D changes must be ignored.
    step(1'b0, 1'b1, 2'b11, 4'hA, "loadA");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00, 4'(i + 3), "hold");

    // Reset mid-count at Q=9.
    step(1'b0, 1'b1, 2'b11, 4'h8, "load8");
    step(1'b0, 1'b1, 2'b00, 4'h0, "up_to9");
    step(1'b1, 1'b1, 2'b00, 4'h0, "reset_mid");
    step(1'b0, 1'b1, 2'b00, 4'h0, "up_after_rst");

    // Random enable/mode/D with occasional reset.
    for (int i = 0; i < 100; i++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
